// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder cell sequenced LSB-first over WIDTH clocks,
// with valid/ready handshakes on both the operand and the result side.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             load, step;
    logic             fa_sum, fa_cout;

    full_adder u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry),
        .sum (fa_sum),
        .cout(fa_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Handshake outputs depend on state only, so no input reaches an output combinationally.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            a_sh   <= in_a;
            b_sh   <= in_b;
            sum_sh <= '0;
            carry  <= in_cin;
            cnt    <= '0;
        end else if (step) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
            carry  <= fa_cout;
            cnt    <= cnt + 1'b1;
        end
    end

    // Result registers hold after the handshake until the next RUN pass reloads them.
    assign out_sum  = sum_sh;
    assign out_cout = carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and back-to-back random checks of serial_add_ctrl at WIDTH = 8, 2 and 32.

module tb_serial_add_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] op_a, op_b;
    logic        op_cin;
    logic [2:0]  iv, ordy, ir, ov, bsy, cout;
    logic [7:0]  sum0;
    logic [1:0]  sum1;
    logic [31:0] sum2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_ctrl #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_a(op_a[7:0]), .in_b(op_b[7:0]), .in_cin(op_cin),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(sum0),
        .out_cout(cout[0]), .busy(bsy[0]));

    serial_add_ctrl #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_a(op_a[1:0]), .in_b(op_b[1:0]), .in_cin(op_cin),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(sum1),
        .out_cout(cout[1]), .busy(bsy[1]));

    serial_add_ctrl #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_a(op_a), .in_b(op_b), .in_cin(op_cin),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(sum2),
        .out_cout(cout[2]), .busy(bsy[2]));

    function automatic int width_of(input int k);
        return (k == 0) ? 8 : (k == 1) ? 2 : 32;
    endfunction

    function automatic logic [63:0] result_of(input int k);
        logic [63:0] s;
        s = (k == 0) ? {56'd0, sum0} : (k == 1) ? {62'd0, sum1} : {32'd0, sum2};
        return s | ({63'd0, cout[k]} << width_of(k));
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Accept-interval and result monitor, sampled mid-cycle.
    logic [2:0]  b2b = 3'b000;
    int          last_acc[3] = '{-1, -1, -1};
    logic [63:0] got_q[3][$];

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst && iv[k] && ir[k]) begin
                if (b2b[k] && last_acc[k] >= 0)
                    check($sformatf("issue_interval_w%0d", width_of(k)),
                          64'(cyc + 1 - last_acc[k]), 64'(width_of(k) + 2));
                last_acc[k] = cyc + 1;
            end
            if (!rst && ov[k] && ordy[k]) got_q[k].push_back(result_of(k));
        end
    end

    // Present a request and return just after the edge that accepts it.
    task automatic start_op(input int k, input logic [31:0] a, input logic [31:0] b,
                            input logic c, input bit keep_valid);
        int n;
        op_a   = a;
        op_b   = b;
        op_cin = c;
        iv[k]  = 1'b1;
        n      = 0;
        forever begin
            @(negedge clk);
            if (ir[k]) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!keep_valid) iv[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k, output int lat);
        lat = 0;
        while (!ov[k] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs[8];

    task automatic random_run(input int k, input int n);
        int          w;
        logic [63:0] mask, exp_q[$];
        logic [31:0] a, b;
        logic        c;
        w        = width_of(k);
        mask     = (64'd1 << w) - 64'd1;
        got_q[k].delete();
        last_acc[k] = -1;
        b2b[k]   = 1'b1;
        ordy[k]  = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                a = 32'hFFFF_FFFF;
                b = 32'hFFFF_FFFF;
                c = 1'b1;
            end else begin
                a = $urandom;
                b = $urandom;
                c = 1'($urandom_range(0, 1));
            end
            a = 32'(64'(a) & mask);
            b = 32'(64'(b) & mask);
            exp_q.push_back(64'(a) + 64'(b) + 64'(c));
            start_op(k, a, b, c, 1'b1);
        end
        iv[k] = 1'b0;
        for (int t = 0; t < 200 && got_q[k].size() < n; t++) @(posedge clk);
        #1;
        b2b[k] = 1'b0;
        check($sformatf("result_count_w%0d", w), 64'(got_q[k].size()), 64'(n));
        for (int i = 0; i < n && i < got_q[k].size(); i++)
            check($sformatf("rand_w%0d_%0d", w, i), got_q[k][i], exp_q[i]);
    endtask

    initial begin
        int lat;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[4] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[7] = '{8'h10, 8'h0F, 1'b0, 8'h1F, 1'b0};

        rst    = 1'b1;
        iv     = 3'b000;
        ordy   = 3'b111;
        op_a   = '0;
        op_b   = '0;
        op_cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_out_valid", 64'(ov[0]), 64'd0);
        check("reset_in_ready", 64'(ir[0]), 64'd1);
        check("reset_busy", 64'(bsy[0]), 64'd0);
        check("reset_result", result_of(0), 64'd0);

        foreach (vecs[i]) begin
            start_op(0, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].cin, 1'b0);
            check($sformatf("vec%0d_busy_run", i), 64'(bsy[0]), 64'd1);
            check($sformatf("vec%0d_in_ready_run", i), 64'(ir[0]), 64'd0);
            wait_valid(0, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd8);
            check($sformatf("vec%0d_result", i), result_of(0), {55'd0, vecs[i].cout, vecs[i].sum});
            check($sformatf("vec%0d_busy_done", i), 64'(bsy[0]), 64'd1);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_idle_after", i), {62'd0, ir[0], bsy[0]}, 64'b10);
        end

        // Backpressure: result held while out_ready low; stray requests ignored.
        ordy[0] = 1'b0;
        start_op(0, 32'h3C, 32'h42, 1'b1, 1'b0);
        wait_valid(0, lat);
        check("bp_latency", 64'(lat), 64'd8);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold_%0d", i), {61'd0, ov[0], ir[0], cout[0]} << 8 | 64'(sum0),
                  {61'd0, 1'b1, 1'b0, 1'b0} << 8 | 64'h7F);
            op_a  = 32'hFF;
            op_b  = 32'hFF;
            iv[0] = 1'b1;
            @(posedge clk);
            #1;
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_idle", {62'd0, ir[0], ov[0]}, 64'b10);
        check("bp_sum_holds", result_of(0), 64'h7F);
        @(posedge clk);
        #1;
        check("bp_no_extra_accept", 64'(bsy[0]), 64'd0);

        // Reset after RUN cycle 3 aborts the operation.
        start_op(0, 32'h12, 32'h34, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_state", {61'd0, ov[0], ir[0], bsy[0]}, 64'b010);
        check("abort_result", result_of(0), 64'd0);
        repeat (12) begin
            @(posedge clk);
            #1;
            check("abort_no_valid", 64'(ov[0]), 64'd0);
        end
        start_op(0, 32'h01, 32'h02, 1'b0, 1'b0);
        wait_valid(0, lat);
        check("after_abort_result", result_of(0), 64'h03);
        @(posedge clk);
        #1;

        random_run(0, 200);
        random_run(1, 200);
        random_run(2, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
